// File: rtl/e203_exu_bjp_resolver_pkg.sv
// Shared types and widths for the EXU branch/jump resolver slice.
package e203_exu_bjp_resolver_pkg;

    // Core PC width; every PC-carrying port in the slice is sized from this.
    localparam int unsigned E203_PC_SIZE = 32;

    // Flush interface toward the IFU: request bit plus restart PC.
    localparam int unsigned E203_FLUSH_W = E203_PC_SIZE + 1;

    typedef enum logic {
        BJP_IDLE = 1'b0,
        BJP_REQ  = 1'b1
    } bjp_state_e;

endpackage

// File: rtl/e203_exu_bjp_resolver_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for performance CSRs.
module e203_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/e203_exu_bjp_resolver.sv
// Resolves IFU-predicted branches at commit and requests an IFU flush on mispredict.
module e203_exu_bjp_resolver
    import e203_exu_bjp_resolver_pkg::*;
#(
    parameter int unsigned PC_SIZE = E203_PC_SIZE,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmt_bjp_valid,
    output logic               cmt_bjp_ready,
    input  logic [PC_SIZE-1:0] cmt_bjp_pc,
    input  logic               cmt_bjp_len2,
    input  logic               cmt_bjp_prdt,
    input  logic               cmt_bjp_rslv,
    input  logic [PC_SIZE-1:0] cmt_bjp_tgt,
    output logic               flush_req,
    output logic [PC_SIZE-1:0] flush_pc,
    input  logic               flush_ack,
    input  logic               flush_kill,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   brch_cnt,
    output logic [CNT_W-1:0]   mis_cnt
);

    bjp_state_e         state;
    logic               acc;
    logic               mis;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] nxt_pc;

    // Branches are only taken while no flush is outstanding.
    assign cmt_bjp_ready = (state == BJP_IDLE);
    assign acc           = cmt_bjp_valid & cmt_bjp_ready;
    assign mis           = acc & (cmt_bjp_prdt ^ cmt_bjp_rslv);

    // Restart PC: resolved target if taken, else fall-through (wraps modulo 2^PC_SIZE).
    always_comb begin
        seq_pc = cmt_bjp_pc + (cmt_bjp_len2 ? PC_SIZE'(2) : PC_SIZE'(4));
        nxt_pc = cmt_bjp_rslv ? cmt_bjp_tgt : seq_pc;
    end

    // Flush FSM; flush_req is a flop so ack/kill never reach it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BJP_IDLE;
            flush_req <= 1'b0;
            flush_pc  <= '0;
        end else begin
            case (state)
                BJP_IDLE: begin
                    if (mis && !flush_kill) begin
                        state     <= BJP_REQ;
                        flush_req <= 1'b1;
                        flush_pc  <= {nxt_pc[PC_SIZE-1:1], 1'b0};
                    end
                end
                BJP_REQ: begin
                    // Kill and ack both retire the request; flush_pc stays frozen.
                    if (flush_kill || flush_ack) begin
                        state     <= BJP_IDLE;
                        flush_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= BJP_IDLE;
                    flush_req <= 1'b0;
                end
            endcase
        end
    end

    e203_sat_cnt #(.CNT_W(CNT_W)) u_brch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (acc),
        .clr (cnt_clr),
        .cnt (brch_cnt)
    );

    e203_sat_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mis),
        .clr (cnt_clr),
        .cnt (mis_cnt)
    );

endmodule

// File: tb/tb_e203_exu_bjp_resolver.sv
// Directed self-checking bench for e203_exu_bjp_resolver.
module tb_e203_exu_bjp_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_bjp_valid;
    logic        cmt_bjp_ready;
    logic [31:0] cmt_bjp_pc;
    logic        cmt_bjp_len2;
    logic        cmt_bjp_prdt;
    logic        cmt_bjp_rslv;
    logic [31:0] cmt_bjp_tgt;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        flush_ack;
    logic        flush_kill;
    logic        cnt_clr;
    logic [31:0] brch_cnt;
    logic [31:0] mis_cnt;

    logic        ready4;
    logic        flush_req4;
    logic [31:0] flush_pc4;
    logic [3:0]  brch_cnt4;
    logic [3:0]  mis_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    e203_exu_bjp_resolver #(.PC_SIZE(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmt_bjp_valid(cmt_bjp_valid), .cmt_bjp_ready(cmt_bjp_ready),
        .cmt_bjp_pc(cmt_bjp_pc), .cmt_bjp_len2(cmt_bjp_len2),
        .cmt_bjp_prdt(cmt_bjp_prdt), .cmt_bjp_rslv(cmt_bjp_rslv),
        .cmt_bjp_tgt(cmt_bjp_tgt),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .flush_ack(flush_ack), .flush_kill(flush_kill),
        .cnt_clr(cnt_clr), .brch_cnt(brch_cnt), .mis_cnt(mis_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation checks.
    e203_exu_bjp_resolver #(.PC_SIZE(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .cmt_bjp_valid(cmt_bjp_valid), .cmt_bjp_ready(ready4),
        .cmt_bjp_pc(cmt_bjp_pc), .cmt_bjp_len2(cmt_bjp_len2),
        .cmt_bjp_prdt(cmt_bjp_prdt), .cmt_bjp_rslv(cmt_bjp_rslv),
        .cmt_bjp_tgt(cmt_bjp_tgt),
        .flush_req(flush_req4), .flush_pc(flush_pc4),
        .flush_ack(flush_ack), .flush_kill(flush_kill),
        .cnt_clr(cnt_clr), .brch_cnt(brch_cnt4), .mis_cnt(mis_cnt4)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bjp(input logic [31:0] pc, input logic len2,
                             input logic prdt, input logic rslv,
                             input logic [31:0] tgt);
        cmt_bjp_valid = 1'b1;
        cmt_bjp_pc    = pc;
        cmt_bjp_len2  = len2;
        cmt_bjp_prdt  = prdt;
        cmt_bjp_rslv  = rslv;
        cmt_bjp_tgt   = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmt_bjp_valid = 1'b0; cmt_bjp_pc = '0; cmt_bjp_len2 = 1'b0;
        cmt_bjp_prdt = 1'b0; cmt_bjp_rslv = 1'b0; cmt_bjp_tgt = '0;
        flush_ack = 1'b0; flush_kill = 1'b0; cnt_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        n_checks++; if (flush_req !== 1'b0) begin n_fail++; $display("FAIL reset_flush_req got %0b want 0", flush_req); end
        n_checks++; if (cmt_bjp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", cmt_bjp_ready); end
        n_checks++; if (flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc got %h want 0", flush_pc); end
        n_checks++; if (brch_cnt !== 32'd0 || mis_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", brch_cnt, mis_cnt); end
    endtask

    task automatic test_mispredict_not_taken();
        drive_bjp(32'h8000_0100, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        step();
        cmt_bjp_valid = 1'b0;
        n_checks++; if (flush_req !== 1'b1) begin n_fail++; $display("FAIL mnt_flush_req got %0b want 1", flush_req); end
        n_checks++; if (flush_pc !== 32'h8000_0104) begin n_fail++; $display("FAIL mnt_flush_pc got %h want 80000104", flush_pc); end
        n_checks++; if (cmt_bjp_ready !== 1'b0) begin n_fail++; $display("FAIL mnt_ready got %0b want 0", cmt_bjp_ready); end
        n_checks++; if (mis_cnt !== 32'd1 || brch_cnt !== 32'd1) begin n_fail++; $display("FAIL mnt_cnts got %0d/%0d want 1/1", brch_cnt, mis_cnt); end
        step();
        n_checks++; if (flush_req !== 1'b1) begin n_fail++; $display("FAIL mnt_hold got %0b want 1", flush_req); end
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        n_checks++; if (flush_req !== 1'b0 || cmt_bjp_ready !== 1'b1) begin n_fail++; $display("FAIL mnt_ack got req=%0b rdy=%0b want 0/1", flush_req, cmt_bjp_ready); end
    endtask

    task automatic test_mispredict_taken();
        drive_bjp(32'h8000_0200, 1'b0, 1'b0, 1'b1, 32'h8000_0040);
        step();
        cmt_bjp_valid = 1'b0;
        n_checks++; if (flush_req !== 1'b1 || flush_pc !== 32'h8000_0040) begin n_fail++; $display("FAIL mt_flush got req=%0b pc=%h want 1/80000040", flush_req, flush_pc); end
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        drive_bjp(32'h8000_0300, 1'b0, 1'b1, 1'b1, 32'h8000_0400);
        step();
        cmt_bjp_valid = 1'b0;
        n_checks++; if (flush_req !== 1'b0) begin n_fail++; $display("FAIL correct_no_flush got %0b want 0", flush_req); end
        n_checks++; if (brch_cnt !== 32'd3 || mis_cnt !== 32'd2) begin n_fail++; $display("FAIL correct_cnts got %0d/%0d want 3/2", brch_cnt, mis_cnt); end
    endtask

    task automatic test_wrap_and_hold();
        drive_bjp(32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0000_1000);
        step();
        n_checks++; if (flush_req !== 1'b1 || flush_pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap got req=%0b pc=%h want 1/00000000", flush_req, flush_pc); end
        // A second mispredict presented while in REQ must be neither accepted nor latched.
        drive_bjp(32'h0000_2000, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
        step();
        cmt_bjp_valid = 1'b0;
        n_checks++; if (flush_pc !== 32'h0000_0000 || flush_req !== 1'b1) begin n_fail++; $display("FAIL req_frozen got req=%0b pc=%h want 1/00000000", flush_req, flush_pc); end
        n_checks++; if (brch_cnt !== 32'd4 || mis_cnt !== 32'd3) begin n_fail++; $display("FAIL req_no_accept got %0d/%0d want 4/3", brch_cnt, mis_cnt); end
    endtask

    task automatic test_kill();
        flush_ack = 1'b1; flush_kill = 1'b1;
        step();
        flush_ack = 1'b0; flush_kill = 1'b0;
        n_checks++; if (flush_req !== 1'b0 || cmt_bjp_ready !== 1'b1) begin n_fail++; $display("FAIL ackkill got req=%0b rdy=%0b want 0/1", flush_req, cmt_bjp_ready); end
        step();
        n_checks++; if (flush_req !== 1'b0) begin n_fail++; $display("FAIL ackkill_rereq got %0b want 0", flush_req); end
        n_checks++; if (brch_cnt !== 32'd4 || mis_cnt !== 32'd3) begin n_fail++; $display("FAIL ackkill_cnts got %0d/%0d want 4/3", brch_cnt, mis_cnt); end
        flush_kill = 1'b1;
        drive_bjp(32'h8000_0500, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        cmt_bjp_valid = 1'b0; flush_kill = 1'b0;
        n_checks++; if (flush_req !== 1'b0 || cmt_bjp_ready !== 1'b1) begin n_fail++; $display("FAIL idle_kill got req=%0b rdy=%0b want 0/1", flush_req, cmt_bjp_ready); end
        n_checks++; if (brch_cnt !== 32'd5 || mis_cnt !== 32'd4) begin n_fail++; $display("FAIL idle_kill_cnts got %0d/%0d want 5/4", brch_cnt, mis_cnt); end
    endtask

    task automatic test_reset_mid_request();
        drive_bjp(32'h8000_0600, 1'b1, 1'b0, 1'b1, 32'h8000_0700);
        step();
        cmt_bjp_valid = 1'b0;
        n_checks++; if (flush_req !== 1'b1 || flush_pc !== 32'h8000_0700) begin n_fail++; $display("FAIL mid_setup got req=%0b pc=%h want 1/80000700", flush_req, flush_pc); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (flush_req !== 1'b0 || cmt_bjp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset got req=%0b rdy=%0b want 0/1", flush_req, cmt_bjp_ready); end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++; if (brch_cnt4 !== 4'h0 || mis_cnt4 !== 4'h0) begin n_fail++; $display("FAIL clr4 got %h/%h want 0/0", brch_cnt4, mis_cnt4); end
        for (int i = 0; i < 20; i++) begin
            drive_bjp(32'h8000_1000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0);
            step();
        end
        cmt_bjp_valid = 1'b0;
        n_checks++; if (brch_cnt4 !== 4'hF || mis_cnt4 !== 4'h0) begin n_fail++; $display("FAIL sat4 got %h/%h want F/0", brch_cnt4, mis_cnt4); end
        n_checks++; if (brch_cnt !== 32'd20) begin n_fail++; $display("FAIL sat32 got %0d want 20", brch_cnt); end
        step();
        n_checks++; if (brch_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat4_hold got %h want F", brch_cnt4); end
        cnt_clr = 1'b1;
        drive_bjp(32'h8000_2000, 1'b0, 1'b1, 1'b1, 32'h8000_3000);
        step();
        cnt_clr = 1'b0; cmt_bjp_valid = 1'b0;
        n_checks++; if (brch_cnt4 !== 4'h0 || mis_cnt4 !== 4'h0) begin n_fail++; $display("FAIL clr_win4 got %h/%h want 0/0", brch_cnt4, mis_cnt4); end
        n_checks++; if (brch_cnt !== 32'd0 || mis_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_win32 got %0d/%0d want 0/0", brch_cnt, mis_cnt); end
    endtask

    initial begin
        test_reset();
        test_mispredict_not_taken();
        test_mispredict_taken();
        test_wrap_and_hold();
        test_kill();
        test_reset_mid_request();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
